// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default binary32 widths, canonical quiet NaN,
// exponent bias helper and the exception flag bundle.
package fpu_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  typedef struct packed {
    logic ovf;
    logic nv;
    logic inexact;
  } fpu_flags_t;

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical qNaN for any format: positive, all-ones exponent, top fraction bit set.
  function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fadd_lzc.sv
// Leading-zero counter for the adder normaliser; returns W for an all-zero input.
module fadd_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && d[W-1-i]) begin
        cnt   = CW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754-style adder/subtractor with RNE rounding, exception flags,
// tag passthrough and a global valid/ready stall.
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  input  logic                   op_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   ovf,
  output logic                   nv,
  output logic                   inexact
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int LZ_W = $clog2(MW + 1);
  localparam int EW2  = EXP_W + 2;
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] EMAX_S = EW2'({EXP_W{1'b1}});

  logic en;
  assign in_ready = ~(out_valid & ~out_ready);
  assign en       = in_ready;

  // ---------------- S1: unpack, special detect, swap, align ----------------
  logic                   sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                   z_big, z_small, s_big;
  logic [EXP_W-1:0]       ea, eb, e_big, e_small, d;
  logic [MAN_W-1:0]       fa, fb, fa_f, fb_f, f_big, f_small;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [MW-1:0]          m_big, m_small, m_al;
  logic [2*MW-1:0]        wide;

  assign sa = x1[W-1];
  assign sb = x2[W-1] ^ op_sub;
  assign ea = x1[W-2:MAN_W];
  assign eb = x2[W-2:MAN_W];
  assign fa = x1[MAN_W-1:0];
  assign fb = x2[MAN_W-1:0];

  always_comb begin
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    fa_f   = a_zero ? '0 : fa;
    fb_f   = b_zero ? '0 : fb;
    mag_a  = {ea, fa_f};
    mag_b  = {eb, fb_f};
    if (mag_a >= mag_b) begin
      e_big = ea; f_big = fa_f; z_big = a_zero; s_big = sa;
      e_small = eb; f_small = fb_f; z_small = b_zero;
    end else begin
      e_big = eb; f_big = fb_f; z_big = b_zero; s_big = sb;
      e_small = ea; f_small = fa_f; z_small = a_zero;
    end
    d       = e_big - e_small;
    m_big   = {~z_big, f_big, 3'b000};
    m_small = {~z_small, f_small, 3'b000};
    wide    = '0;
    if (int'(d) >= MW) begin
      m_al = {{(MW-1){1'b0}}, |m_small};
    end else begin
      wide = {m_small, {MW{1'b0}}} >> d;
      m_al = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
    end
  end

  logic             s1_v, s1_sign, s1_sub, s1_nan, s1_inf, s1_isign, s1_zsign;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_mb, s1_ms;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v <= 1'b0;
    end else if (en) begin
      s1_v     <= in_valid;
      s1_sign  <= s_big;
      s1_sub   <= sa ^ sb;
      s1_exp   <= e_big;
      s1_mb    <= m_big;
      s1_ms    <= m_al;
      s1_nan   <= a_nan | b_nan | (a_inf & b_inf & (sa != sb));
      s1_inf   <= a_inf | b_inf;
      s1_isign <= a_inf ? sa : sb;
      s1_zsign <= a_zero & b_zero & sa & sb;
      s1_tag   <= in_tag;
    end
  end

  // ---------------- S2: add/sub, leading-zero count, normalise -------------
  logic [MW:0]           sum;
  logic [LZ_W-1:0]       lz;
  logic [MW-1:0]         norm;
  logic signed [EW2-1:0] e_norm;

  fadd_lzc #(.W(MW), .CW(LZ_W)) u_lzc (.d(sum[MW-1:0]), .cnt(lz));

  // Left shifts of two or more only follow near-equal exponents, where G/R/S are exact.
  always_comb begin
    sum = s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms}) : ({1'b0, s1_mb} + {1'b0, s1_ms});
    if (sum[MW]) begin
      norm   = {sum[MW:2], sum[1] | sum[0]};
      e_norm = EW2'(s1_exp) + EW2'(1);
    end else begin
      norm   = sum[MW-1:0] << lz;
      e_norm = EW2'(s1_exp) - EW2'(lz);
    end
  end

  logic                  s2_v, s2_sign, s2_zero, s2_nan, s2_inf, s2_isign, s2_zsign;
  logic signed [EW2-1:0] s2_exp;
  logic [MW-1:0]         s2_norm;
  logic [TAG_W-1:0]      s2_tag;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_v <= 1'b0;
    end else if (en) begin
      s2_v     <= s1_v;
      s2_sign  <= s1_sign;
      s2_exp   <= e_norm;
      s2_norm  <= norm;
      s2_zero  <= (sum == '0);
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_isign <= s1_isign;
      s2_zsign <= s1_zsign;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------- S3: round, renormalise, range check, pack --------------
  logic                  rup, ix;
  logic [MAN_W+1:0]      mr;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] ef;
  logic [W-1:0]          res;
  fpu_flags_t            fl, flags_q;

  always_comb begin
    rup  = s2_norm[2] & (s2_norm[3] | s2_norm[1] | s2_norm[0]);
    ix   = |s2_norm[2:0];
    mr   = {1'b0, s2_norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    ef   = s2_exp + {{(EW2-1){1'b0}}, mr[MAN_W+1]};
    frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    fl   = '0;
    res  = '0;
    if (s2_nan) begin
      res   = QNAN;
      fl.nv = 1'b1;
    end else if (s2_inf) begin
      res = {s2_isign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      res = {s2_zsign, {(W-1){1'b0}}};
    end else if (ef <= 0) begin
      res        = {s2_sign, {(W-1){1'b0}}};
      fl.inexact = 1'b1;
    end else if (ef >= EMAX_S) begin
      res        = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fl.ovf     = 1'b1;
      fl.inexact = 1'b1;
    end else begin
      res        = {s2_sign, ef[EXP_W-1:0], frac};
      fl.inexact = ix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_tag   <= '0;
      flags_q   <= '0;
    end else if (en) begin
      out_valid <= s2_v;
      y         <= res;
      out_tag   <= s2_tag;
      flags_q   <= s2_v ? fl : '0;
    end
  end

  assign ovf     = flags_q.ovf;
  assign nv      = flags_q.nv;
  assign inexact = flags_q.inexact;
endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Parametrised successor to the FPU's fixed 2-stage adder, for the FPU dispatch path.
- Pipelined IEEE-754-style adder/subtractor with configurable exponent/mantissa widths.
- Adds round-to-nearest-even, an add/sub mode, exception flags, a tag passthrough and valid/ready flow control, so the FPU issue logic can stall it.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
- TAG_W, 5, opaque tag width (destination register id) carried alongside each operation.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- x1  in  W  operand A.
- x2  in  W  operand B.
- op_sub  in  1  0: y=x1+x2, 1: y=x1-x2 (sign of x2 inverted before alignment).
- in_tag  in  TAG_W  tag for this operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  W  rounded result.
- out_tag  out  TAG_W  tag of the result.
- ovf  out  1  finite inputs produced ±inf.
- nv  out  1  invalid operation (NaN input or inf-inf).
- inexact  out  1  rounding discarded nonzero bits.

Behaviour:
- Reset (rstn=0 at posedge): all stage-valid bits cleared; out_valid=0; y, out_tag, ovf, nv, inexact = 0.
- Fixed 3-stage pipeline; a transfer occurs when in_valid&in_ready. Result appears with out_valid=1 exactly 3 cycles later when out_ready has been held at 1.
  - S1: swap by magnitude, special-case detect, align smaller mantissa with guard/round/sticky bits (sticky = OR of bits shifted out; shift ≥ MAN_W+3 leaves sticky only).
  - S2: add/subtract, leading-zero count, normalise.
  - S3: RNE rounding, mantissa carry-out renormalisation, exponent range check, output pack.
- Global stall: in_ready = ~(out_valid & ~out_ready). When stalled, all stage registers hold; no bubble is lost and no result is overwritten.
- Bubbles (stage-valid=0) propagate normally; data registers may update, but valid bits gate outputs.
- Denormal inputs (exp=0) are flushed to zero of the same sign.
- Result below min normal is flushed to ±0 (sign of unrounded result), inexact=1 if nonzero before flush.
- Rounding: RNE on guard/round/sticky; tie rounds to even mantissa LSB.
- Post-round exponent ≥ 2^EXP_W-1: y=±inf, ovf=1, inexact=1.
- Exact cancellation (x+(-x)) gives +0. (-0)+(-0) gives -0. (+0)+(-0) gives +0.
- Any NaN input, or inf + (-inf) after op_sub applied: y = canonical qNaN {0, all-ones exp, 1, zeros}, nv=1, other flags 0.
- inf op finite: y = that inf, all flags 0.
- Flags are valid only when out_valid=1 and are 0 otherwise.
- rstn asserted mid-operation: in-flight operations are discarded; no stale out_valid after reset.

Decomposition:
- Shared package fpu_pkg: EXP_W/MAN_W defaults, canonical qNaN constant, exponent bias function, flag struct {ovf, nv, inexact}.
- One sub-module fadd_lzc (parametrised leading-zero counter, width MAN_W+4), instanced in S2; replaces the priority-mux chain.

Test Plan:
- 0x3F800000 + 0x40000000, op_sub=0, tag=7, out_ready=1 → 3 cycles later y=0x40400000, out_tag=7, all flags 0.
- 0x3F800000 - 0x3F800000 (op_sub=1) → y=0x00000000, flags 0. Separately 0x80000000 + 0x80000000 → y=0x80000000.
- 0x3F800000 + 0x33800000 (exact tie) → y=0x3F800000, inexact=1. 0x3F800000 + 0x33800001 → y=0x3F800001, inexact=1.
- 0x7F7FFFFF + 0x7F7FFFFF → y=0x7F800000, ovf=1, inexact=1. 0x7F800000 - 0x7F800000 → y=0x7FC00000, nv=1. 0x7FC00001 + 0x3F800000 → y=0x7FC00000, nv=1.
- Back-to-back issue of 6 ops with out_ready=0 on cycles 4-7 → in_ready=0 on exactly those stalled cycles. All 6 results emerge in order with correct tags, none dropped or duplicated.
- Assert rstn=0 with 2 ops in flight → out_valid=0 the cycle after reset and stays 0 until a new op completes 3 cycles after issue.
